count_pulse_gen: RTL

- Stimulus-side counterpart of the team's dual event counter: takes two target counts and emits the En/Slt pulse stream that drives that counter to exactly those values.
- Phase A drives the plain counter channel (Slt=0); phase B drives the prescaled channel (Slt=1) with SLT_DIV pulses per increment.
- Used for self-checking loops and as a programmable event source on the board.

---
 rtl/count_pulse_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/count_pulse_gen.sv
// -----------------------------------------------------------------------------
// count_pulse_gen
//
// Stimulus source for the dual event counter. A request carries two target
// counts. The block then emits the En/Slt pulse stream that drives the counter
// to exactly those values:
//   - phase A: Count0 pulses with Slt=0 (plain channel)
//   - phase B: Count1*SLT_DIV pulses with Slt=1 (prescaled channel)
//   - FIN:     a one-cycle Done pulse
//
// Parameters
//   CNT_W    width of the target counts and of the internal down-counters
//   SLT_DIV  Slt pulses per prescaled increment (power of two, >= 2)
//
// Ports
//   Clk     system clock; all state changes on the rising edge
//   Reset   synchronous, active-low reset
//   Start   request strobe, sampled only while idle
//   Count0  target for the Slt=0 channel, latched when Start is accepted
//   Count1  target for the Slt=1 channel, latched when Start is accepted
//   Hold    stall: no pulse is emitted and no progress is made while high
//   En      pulse enable to the counter
//   Slt     channel select to the counter
//   Busy    high while a request is in progress
//   Done    one-cycle completion pulse
// -----------------------------------------------------------------------------
module count_pulse_gen #(
   parameter int CNT_W   = 64,
   parameter int SLT_DIV = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [CNT_W-1:0] Count0,
   input  logic [CNT_W-1:0] Count1,
   input  logic             Hold,
   output logic             En,
   output logic             Slt,
   output logic             Busy,
   output logic             Done
);

   localparam int SUB_W = $clog2(SLT_DIV);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SLT_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND0,
      SEND1,
      FIN
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] rem0, rem0_nxt;
   logic [CNT_W-1:0] rem1, rem1_nxt;
   logic [SUB_W-1:0] sub, sub_nxt;
   logic             sending;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: non-blocking assignments keep every register updating from the
   // pre-edge values, so ordering inside this block cannot change behaviour.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
         rem0  <= '0;
         rem1  <= '0;
         sub   <= '0;
      end else begin
         state <= state_nxt;
         rem0  <= rem0_nxt;
         rem1  <= rem1_nxt;
         sub   <= sub_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every variable gets its hold value first so that no path through
   // the case statement leaves it unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      rem0_nxt  = rem0;
      rem1_nxt  = rem1;
      sub_nxt   = sub;

      case (state)
         IDLE: begin
            if (Start) begin
               rem0_nxt = Count0;
               rem1_nxt = Count1;
               sub_nxt  = '0;
               if (Count0 != '0)
                  state_nxt = SEND0;
               else if (Count1 != '0)
                  state_nxt = SEND1;
               else
                  state_nxt = FIN;
            end
         end

         SEND0: begin
            if (!Hold) begin
               rem0_nxt = rem0 - 1'b1;
               if (rem0 == CNT_W'(1))
                  state_nxt = (rem1 != '0) ? SEND1 : FIN;
            end
         end

         // The prescaled channel is walked as rem1 outer steps of SLT_DIV
         // inner pulses, so Count1*SLT_DIV is never formed and a full-scale
         // Count1 cannot overflow.
         SEND1: begin
            if (!Hold) begin
               if (sub == SUB_LAST) begin
                  sub_nxt  = '0;
                  rem1_nxt = rem1 - 1'b1;
                  if (rem1 == CNT_W'(1))
                     state_nxt = FIN;
               end else begin
                  sub_nxt = sub + SUB_W'(1);
               end
            end
         end

         FIN: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from the state register; En also gated by Hold
   // -------------------------------------------------------------------------
   assign sending = (state == SEND0) || (state == SEND1);
   assign En      = sending && !Hold;
   assign Slt     = (state == SEND1);
   assign Busy    = (state != IDLE);
   assign Done    = (state == FIN);

endmodule
